// File: rtl/sti_req_scheduler_if.sv
// rtl/sti_req_scheduler_if.sv - requester, transmitter and status signal bundle for sti_req_scheduler
interface sti_req_scheduler_if;
  logic        start;
  logic [1:0]  en_mask;
  logic        req0;
  logic        req1;
  logic [15:0] data0;
  logic [15:0] data1;
  logic [4:0]  cfg0;
  logic [4:0]  cfg1;
  logic        last0;
  logic        last1;
  logic        ack0;
  logic        ack1;
  logic        load;
  logic [15:0] pi_data;
  logic [1:0]  pi_length;
  logic        pi_fill;
  logic        pi_msb;
  logic        pi_low;
  logic        pi_end;
  logic        so_valid;
  logic        oem_finish;
  logic        busy;
  logic        grant_id;
  logic        all_done;
  logic        timeout_err;

  // Scheduler side
  modport master (
    input  start, en_mask, req0, req1, data0, data1, cfg0, cfg1, last0, last1,
    input  so_valid, oem_finish,
    output ack0, ack1, load, pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end,
    output busy, grant_id, all_done, timeout_err
  );

  // Requester / transmitter / controller side
  modport slave (
    output start, en_mask, req0, req1, data0, data1, cfg0, cfg1, last0, last1,
    output so_valid, oem_finish,
    input  ack0, ack1, load, pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end,
    input  busy, grant_id, all_done, timeout_err
  );
endinterface

// File: rtl/sti_req_scheduler.sv
// rtl/sti_req_scheduler.sv - round-robin scheduler sharing the serial transmitter between two requesters (optional STI_SCHED_TIMEOUT_EN)
module sti_req_scheduler #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  sti_req_scheduler_if.master    sif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_LOAD,
    S_XFER,
    S_ACK,
    S_END,
    S_FINISH
  } state_t;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  state_t      state_q, state_d;
  logic        rr_q, rr_d;
  logic [1:0]  done_q, done_d;
  logic [1:0]  en_q, en_d;
  logic        gid_q, gid_d;
  logic        last_q, last_d;
  logic [5:0]  exp_q, exp_d;
  logic [5:0]  beat_q, beat_d;
  logic [15:0] pi_data_q, pi_data_d;
  logic [1:0]  pi_length_q, pi_length_d;
  logic        pi_fill_q, pi_fill_d;
  logic        pi_msb_q, pi_msb_d;
  logic        pi_low_q, pi_low_d;
  logic        pi_end_q, pi_end_d;
  logic        all_done_q, all_done_d;
  logic        tmo_err_q, tmo_err_d;
  logic        tmo_hit;

  logic [1:0]  elig;
  logic        pend;
  logic        pick;
  logic [4:0]  cfg_sel;
  logic [5:0]  exp_dec;

  // Arbitration terms and the bit count for the captured length field
  always_comb begin
    elig    = {sif.req1, sif.req0} & en_q & ~done_q;
    pend    = (done_q | ~en_q) != 2'b11;
    pick    = (elig == 2'b11) ? rr_q : elig[1];
    cfg_sel = pick ? sif.cfg1 : sif.cfg0;
    exp_dec = {1'b0, pi_length_q, 3'b000} + 6'd8;
  end

`ifdef STI_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_q, tmo_d;
  logic          tmo_count;

  // Idle-cycle counter: restarts on any sign of life or state change
  always_comb begin
    tmo_count = (state_q == S_XFER) || (state_q == S_FINISH);
    tmo_hit   = tmo_count && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
    if (sif.so_valid || sif.oem_finish || (state_d != state_q)) begin
      tmo_d = '0;
    end else if (tmo_count) begin
      tmo_d = tmo_q + 1'b1;
    end else begin
      tmo_d = tmo_q;
    end
  end

  // Timeout counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Next-state and datapath decisions for the scheduler FSM
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    done_d      = done_q;
    en_d        = en_q;
    gid_d       = gid_q;
    last_d      = last_q;
    exp_d       = exp_q;
    beat_d      = beat_q;
    pi_data_d   = pi_data_q;
    pi_length_d = pi_length_q;
    pi_fill_d   = pi_fill_q;
    pi_msb_d    = pi_msb_q;
    pi_low_d    = pi_low_q;
    pi_end_d    = pi_end_q;
    all_done_d  = all_done_q;
    tmo_err_d   = tmo_err_q;

    case (state_q)
      S_IDLE: begin
        if (sif.start) begin
          done_d     = 2'b00;
          all_done_d = 1'b0;
          tmo_err_d  = 1'b0;
          en_d       = sif.en_mask;
          state_d    = S_ARB;
        end
      end
      S_ARB: begin
        if (!pend) begin
          pi_data_d = 16'h0000;
          pi_end_d  = 1'b1;
          state_d   = S_END;
        end else if (|elig) begin
          gid_d       = pick;
          rr_d        = ~pick;
          pi_data_d   = pick ? sif.data1 : sif.data0;
          last_d      = pick ? sif.last1 : sif.last0;
          pi_length_d = cfg_sel[4:3];
          pi_fill_d   = cfg_sel[2];
          pi_msb_d    = cfg_sel[1];
          pi_low_d    = cfg_sel[0];
          pi_end_d    = 1'b0;
          state_d     = S_LOAD;
        end
      end
      S_LOAD: begin
        exp_d   = exp_dec;
        beat_d  = 6'd0;
        state_d = S_XFER;
      end
      S_XFER: begin
        if (sif.so_valid) begin
          beat_d = beat_q + 6'd1;
          if ((beat_q + 6'd1) == exp_q) begin
            state_d = S_ACK;
          end
        end else if (tmo_hit) begin
          tmo_err_d = 1'b1;
          state_d   = S_ACK;
        end
      end
      S_ACK: begin
        if (last_q) begin
          if (gid_q) begin
            done_d[1] = 1'b1;
          end else begin
            done_d[0] = 1'b1;
          end
        end
        state_d = S_ARB;
      end
      S_END: begin
        state_d = S_FINISH;
      end
      S_FINISH: begin
        if (sif.oem_finish) begin
          all_done_d = 1'b1;
          state_d    = S_IDLE;
        end else if (tmo_hit) begin
          tmo_err_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any transfer without an ack
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rr_q        <= 1'b0;
      done_q      <= 2'b00;
      en_q        <= 2'b00;
      gid_q       <= 1'b0;
      last_q      <= 1'b0;
      exp_q       <= 6'd0;
      beat_q      <= 6'd0;
      pi_data_q   <= 16'h0000;
      pi_length_q <= 2'b00;
      pi_fill_q   <= 1'b0;
      pi_msb_q    <= 1'b0;
      pi_low_q    <= 1'b0;
      pi_end_q    <= 1'b0;
      all_done_q  <= 1'b0;
      tmo_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      done_q      <= done_d;
      en_q        <= en_d;
      gid_q       <= gid_d;
      last_q      <= last_d;
      exp_q       <= exp_d;
      beat_q      <= beat_d;
      pi_data_q   <= pi_data_d;
      pi_length_q <= pi_length_d;
      pi_fill_q   <= pi_fill_d;
      pi_msb_q    <= pi_msb_d;
      pi_low_q    <= pi_low_d;
      pi_end_q    <= pi_end_d;
      all_done_q  <= all_done_d;
      tmo_err_q   <= tmo_err_d;
    end
  end

  assign sif.load        = (state_q == S_LOAD) || (state_q == S_END);
  assign sif.ack0        = (state_q == S_ACK) && !gid_q;
  assign sif.ack1        = (state_q == S_ACK) && gid_q;
  assign sif.busy        = (state_q != S_IDLE);
  assign sif.grant_id    = gid_q;
  assign sif.pi_data     = pi_data_q;
  assign sif.pi_length   = pi_length_q;
  assign sif.pi_fill     = pi_fill_q;
  assign sif.pi_msb      = pi_msb_q;
  assign sif.pi_low      = pi_low_q;
  assign sif.pi_end      = pi_end_q;
  assign sif.all_done    = all_done_q;
  assign sif.timeout_err = tmo_err_q;

endmodule

// File: tb/tb_sti_req_scheduler.sv
// tb/tb_sti_req_scheduler.sv - directed self-checking bench for sti_req_scheduler
module tb_sti_req_scheduler;

  logic clk;
  logic reset;

  int n_checks;
  int n_fail;
  int n_data_loads;
  int n_end_loads;
  int n_acks;
  int n_dbl_load;
  logic load_prev;

  sti_req_scheduler_if sif ();

  sti_req_scheduler #(.TIMEOUT_CYCLES(64)) dut (
    .clk   (clk),
    .reset (reset),
    .sif   (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event log sampled on the falling edge
  always @(negedge clk) begin
    if (sif.load && !sif.pi_end) n_data_loads <= n_data_loads + 1;
    if (sif.load && sif.pi_end)  n_end_loads  <= n_end_loads + 1;
    if (sif.ack0 || sif.ack1)    n_acks       <= n_acks + 1;
    if (sif.load && load_prev)   n_dbl_load   <= n_dbl_load + 1;
    load_prev <= sif.load;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {4'h0, sif.ack0, sif.ack1, sif.load, sif.pi_data, sif.pi_length, sif.pi_fill,
            sif.pi_msb, sif.pi_low, sif.pi_end, sif.busy, sif.grant_id, sif.all_done,
            sif.timeout_err};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    sif.start = 0; sif.en_mask = 0; sif.req0 = 0; sif.req1 = 0;
    sif.data0 = 0; sif.data1 = 0; sif.cfg0 = 0; sif.cfg1 = 0;
    sif.last0 = 0; sif.last1 = 0; sif.so_valid = 0; sif.oem_finish = 0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    clear_inputs();
    repeat (3) tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic start_session(input logic [1:0] mask);
    sif.en_mask = mask;
    sif.start = 1'b1;
    tick();
    sif.start = 1'b0;
  endtask

  task automatic wait_load(input string tag, output int n);
    n = 0;
    while (!sif.load && n < 20) begin
      tick();
      n++;
    end
    check({tag, " load"}, {31'b0, sif.load}, 32'd1);
  endtask

  // Called in the LOAD cycle: n beats with gap idle cycles between them, then check the ack
  task automatic send_word(input string tag, input int n, input int gap, input logic id);
    int a0;
    tick();
    a0 = n_acks;
    for (int i = 0; i < n - 1; i++) begin
      sif.so_valid = 1'b1;
      tick();
      sif.so_valid = 1'b0;
      repeat (gap) tick();
    end
    check({tag, " early ack"}, (n_acks - a0) + int'(sif.ack0) + int'(sif.ack1), 32'd0);
    sif.so_valid = 1'b1;
    tick();
    sif.so_valid = 1'b0;
    check({tag, " ack"}, {30'b0, sif.ack1, sif.ack0}, id ? 32'd2 : 32'd1);
  endtask

  task automatic finish_session(input string tag);
    int n;
    wait_load({tag, " end"}, n);
    check({tag, " pi_end"}, {15'b0, sif.pi_end, sif.pi_data}, 32'h0001_0000);
    tick();
    sif.oem_finish = 1'b1;
    tick();
    sif.oem_finish = 1'b0;
    check({tag, " all_done"}, {30'b0, sif.all_done, sif.busy}, 32'd2);
  endtask

  initial begin
    int n;
    int dl0, el0, ak0;
    n_checks = 0; n_fail = 0;
    n_data_loads = 0; n_end_loads = 0; n_acks = 0; n_dbl_load = 0;
    load_prev = 1'b0;
    reset = 1'b1;
    clear_inputs();

    // Reset state
    repeat (2) tick();
    check("reset outs", outs(), 32'd0);
    reset = 1'b0;
    tick();

    // Single word
    start_session(2'b01);
    check("single busy", {31'b0, sif.busy}, 32'd1);
    sif.req0 = 1; sif.data0 = 16'hA5C3; sif.cfg0 = 5'b01_0_1_0; sif.last0 = 1;
    wait_load("single", n);
    check("single grant latency", n, 32'd1);
    check("single pi", {sif.pi_data, 8'b0, sif.pi_length, sif.pi_fill, sif.pi_msb, sif.pi_low, sif.pi_end},
          {16'hA5C3, 8'b0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0});
    send_word("single", 16, 0, 1'b0);
    sif.req0 = 0;
    tick();
    check("single ack width", {30'b0, sif.ack1, sif.ack0}, 32'd0);
    finish_session("single");

    // Round robin, three words each
    apply_reset();
    dl0 = n_data_loads; el0 = n_end_loads;
    start_session(2'b11);
    sif.req0 = 1; sif.req1 = 1;
    sif.data0 = 16'h0100; sif.data1 = 16'h1100;
    sif.cfg0 = 5'b00_000; sif.cfg1 = 5'b00_000;
    for (int w = 0; w < 6; w++) begin
      wait_load($sformatf("rr%0d", w), n);
      check($sformatf("rr%0d grant", w), {31'b0, sif.grant_id}, w % 2);
      check($sformatf("rr%0d data", w), {16'b0, sif.pi_data},
            (w % 2 == 1) ? 32'h1100 + w / 2 : 32'h0100 + w / 2);
      send_word($sformatf("rr%0d", w), 8, 0, w % 2 == 1);
      if (w % 2 == 0) begin
        sif.data0 = sif.data0 + 1;
        sif.last0 = (w / 2 == 1);
      end else begin
        sif.data1 = sif.data1 + 1;
        sif.last1 = (w / 2 == 1);
      end
    end
    sif.req0 = 0; sif.req1 = 0;
    finish_session("rr");
    tick();
    check("rr data loads", n_data_loads - dl0, 32'd6);
    check("rr end loads", n_end_loads - el0, 32'd1);

    // Length decode with gapped beats
    apply_reset();
    start_session(2'b01);
    sif.req0 = 1; sif.data0 = 16'h2424; sif.cfg0 = 5'b10_101; sif.last0 = 0;
    wait_load("len24", n);
    check("len24 pi", {sif.pi_length, sif.pi_fill, sif.pi_msb, sif.pi_low}, 32'b10_101);
    send_word("len24", 24, 2, 1'b0);
    sif.data0 = 16'h3232; sif.cfg0 = 5'b11_000; sif.last0 = 1;
    wait_load("len32", n);
    check("len32 pi", {sif.pi_data, 14'b0, sif.pi_length}, {16'h3232, 14'b0, 2'b11});
    send_word("len32", 32, 2, 1'b0);
    sif.req0 = 0;
    finish_session("len");

    // Empty session
    apply_reset();
    dl0 = n_data_loads;
    start_session(2'b00);
    check("empty arb", {31'b0, sif.load}, 32'd0);
    tick();
    check("empty end cycle3", {14'b0, sif.load, sif.pi_end, sif.pi_data}, 32'h0003_0000);
    tick();
    check("empty finish", {30'b0, sif.load, sif.busy}, 32'd1);
    sif.oem_finish = 1;
    tick();
    sif.oem_finish = 0;
    check("empty all_done", {31'b0, sif.all_done}, 32'd1);
    tick();
    check("empty data loads", n_data_loads - dl0, 32'd0);

    // Reset during XFER
    apply_reset();
    start_session(2'b01);
    sif.req0 = 1; sif.data0 = 16'hBEEF; sif.cfg0 = 5'b01_000; sif.last0 = 1;
    wait_load("abort", n);
    tick();
    repeat (5) begin
      sif.so_valid = 1; tick();
    end
    sif.so_valid = 0;
    ak0 = n_acks;
    #1 reset = 1'b1;
    #1;
    check("abort outs", outs(), 32'd0);
    clear_inputs();
    repeat (3) tick();
    check("abort no ack", n_acks - ak0, 32'd0);
    reset = 1'b0;
    tick();
    start_session(2'b01);
    check("fresh all_done", {31'b0, sif.all_done}, 32'd0);
    sif.req0 = 1; sif.data0 = 16'h1234; sif.cfg0 = 5'b00_000; sif.last0 = 1;
    wait_load("fresh", n);
    check("fresh data", {16'b0, sif.pi_data}, 32'h1234);
    send_word("fresh", 8, 0, 1'b0);
    sif.req0 = 0;
    finish_session("fresh");

    // Stalled transmitter
    apply_reset();
    start_session(2'b01);
    sif.req0 = 1; sif.data0 = 16'h0F0F; sif.cfg0 = 5'b00_000; sif.last0 = 1;
    wait_load("stall", n);
    tick();
    repeat (3) begin
      sif.so_valid = 1; tick();
    end
    sif.so_valid = 0;
    ak0 = n_acks;
`ifdef STI_SCHED_TIMEOUT_EN
    n = 0;
    while (!sif.ack0 && n < 100) begin
      tick();
      n++;
    end
    check("stall ack delay", n, 32'd64);
    check("stall timeout_err", {31'b0, sif.timeout_err}, 32'd1);
    sif.req0 = 0;
    tick();
    check("stall acks", n_acks - ak0, 32'd1);
`else
    repeat (80) tick();
    check("stall no ack", n_acks - ak0, 32'd0);
    check("stall flags", {30'b0, sif.busy, sif.timeout_err}, 32'd2);
`endif
    apply_reset();

    check("no back-to-back load", n_dbl_load, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sti_req_scheduler.md
Name: sti_req_scheduler

Overview:
- Round-robin scheduler that shares the single serial transmitter / data-arrangement datapath between two word requesters.
- Grants one requester, drives a one-cycle load with that requester's word and format fields, and counts so_valid beats until the serialised word completes.
- Acks the requester, then re-arbitrates.
- Once every enabled requester has delivered its last word, issues the pi_end load and waits for oem_finish.

Parameters:
- TIMEOUT_CYCLES, 64: cycles without so_valid (XFER) or oem_finish (FINISH) before timeout; used only with STI_SCHED_TIMEOUT_EN.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse; begins a session and clears done flags
- en_mask  input  2  requester enables, sampled on start
- req0 / req1  input  1  word request; held until matching ack
- data0 / data1  input  16  word payload
- cfg0 / cfg1  input  5  {length[1:0], fill, msb, low}
- last0 / last1  input  1  this word is the requester's final word
- ack0 / ack1  output  1  one-cycle completion pulse
- load  output  1  one-cycle load strobe to transmitter
- pi_data  output  16  registered payload
- pi_length  output  2  registered length
- pi_fill, pi_msb, pi_low, pi_end  output  1  registered format/end flags
- so_valid  input  1  serial bit-valid from transmitter
- oem_finish  input  1  memory write-out complete
- busy  output  1  high in any state other than IDLE
- grant_id  output  1  index of current/last grant
- all_done  output  1  sticky session-complete flag
- timeout_err  output  1  sticky timeout flag

Behaviour:
- Reset: all outputs 0, state IDLE, rr pointer 0, done flags 0, counters 0.
- Reset mid-operation aborts immediately; no ack is issued.
- FSM states: IDLE, ARB, LOAD, XFER, ACK, END, FINISH.
- IDLE:
  - start -> ARB; clears done[1:0], all_done and timeout_err; latches en_mask.
  - start is ignored outside IDLE.
- ARB:
  - eligible[i] = req_i & en[i] & ~done[i].
  - pend = (done | ~en) != 2'b11. If !pend -> END.
  - Else, if any eligible: grant it and go to LOAD.
  - If both are eligible, grant the requester indexed by the rr pointer.
  - On grant: capture data/cfg/last into the output registers; grant_id = index; rr pointer = ~index.
  - Else stay in ARB.
- LOAD:
  - load = 1 for exactly this cycle, with pi_* stable and pi_end = 0.
  - Load expected bit count: length 00->8, 01->16, 10->24, 11->32. Use a 6-bit counter; clear the beat count.
  - -> XFER.
- XFER:
  - Each cycle with so_valid high increments the beat count.
  - Beat count reaching expected -> ACK.
  - so_valid seen in LOAD or ARB is ignored.
- ACK:
  - ack[grant_id] = 1 for one cycle.
  - If the captured last is set, set done[grant_id].
  - -> ARB. The requester may drop or renew req in the following cycle.
  - A req still held in the ACK cycle is not re-granted until ARB.
- END:
  - load = 1 and pi_end = 1 for one cycle; pi_data = 0; other pi_* keep their last values.
  - -> FINISH.
- FINISH:
  - oem_finish high -> all_done = 1, state IDLE.
- pi_* hold their values between loads; load is never high in two consecutive cycles.
- Latency:
  - Grant to load: 1 cycle.
  - Final beat to ack: 1 cycle.
  - Word with both requesters idle: ack at req + 3 + expected + so_valid gaps.
- en_mask = 00 at start: ARB -> END immediately; the session produces no data loads.
- Requester deasserting req before ack: protocol violation; the scheduler completes the transfer and still pulses ack.

Optional Feature:
- Macro STI_SCHED_TIMEOUT_EN.
- When defined, a timeout counter clears on every so_valid, on every state entry and on oem_finish, and counts in XFER and FINISH.
  - Reaching TIMEOUT_CYCLES in XFER: set timeout_err, go to ACK (ack still issued).
  - Reaching TIMEOUT_CYCLES in FINISH: set timeout_err, go to IDLE with all_done = 0.
- When not defined: no counter is present, timeout_err is tied 0, and the scheduler waits indefinitely.

Test Plan:
- Single word: en_mask=01, start, req0 with data0=16'hA5C3, cfg0=5'b01_0_1_0, last0=1; 16 so_valid beats.
  - Expect load for one cycle with pi_data=A5C3 and pi_length=01.
  - Expect ack0 one cycle after the 16th beat, then a pi_end load; oem_finish -> all_done=1.
- Round robin: en_mask=11, req0 and req1 held continuously, 3 words each (last on the third), length 00.
  - Expect grant order 0,1,0,1,0,1, each ack after 8 beats.
  - Expect exactly one pi_end load after the sixth ack.
- Length decode: cfg length 10 and 11 words with gapped so_valid (1 in 3 cycles).
  - Expect ack only after 24 and 32 beats respectively.
- Empty session: en_mask=00, start.
  - Expect no data load; END load with pi_end=1 in cycle 3; all_done after oem_finish.
- Reset mid-XFER: assert reset after 5 of 16 beats.
  - Expect all outputs 0 at once, no ack; a new start behaves as a fresh session.
- With STI_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=64: stop so_valid after 3 of 8 beats.
  - Expect timeout_err=1 and ack 64 cycles after the last beat.
  - Without the macro: no ack, timeout_err=0.
